// File: rtl/rv_dec_pkg.sv
// rtl/rv_dec_pkg.sv - shared constants and types for the fetch/decode front end
// Purpose: RV opcode/funct encodings, control-word bit positions, instruction
//          format enum and fetch FSM states used by rv_inst_decoder and
//          rv_fetch_decode.
// Ports:   none (package).
package rv_dec_pkg;

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // funct3 values
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_DWORD   = 3'b011;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_JALR    = 3'b000;

  // funct7 values
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Control word layout
  localparam int CTRL_W        = 12;
  localparam int CTRL_JAL      = 11;
  localparam int CTRL_JALR     = 10;
  localparam int CTRL_BRANCH   = 9;
  localparam int CTRL_MEMREAD  = 8;
  localparam int CTRL_MEMWRITE = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_REGWRITE = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_ALT      = 3;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_J,
    FMT_ILL
  } fmt_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } fd_state_e;

endpackage

// File: rtl/rv_fetch_decode_if.sv
// rtl/rv_fetch_decode_if.sv - instruction-memory, redirect and decode handshake bundle
// Purpose: groups every non-clock signal of rv_fetch_decode.
// Signals: imem_req/imem_addr (fetch request), imem_rvalid/imem_rdata (read data),
//          redirect_valid/redirect_addr (flush + refetch), dec_valid/dec_ready
//          handshake with dec_pc/dec_ctrl/dec_imm/dec_illegal payload.
// Modports: master = fetch/decode unit, slave = memory + execute environment.
interface rv_fetch_decode_if
  import rv_dec_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 30
);
  logic              imem_req;
  logic [AW-1:0]     imem_addr;
  logic              imem_rvalid;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [AW-1:0]     redirect_addr;
  logic              dec_valid;
  logic              dec_ready;
  logic [AW-1:0]     dec_pc;
  logic [CTRL_W-1:0] dec_ctrl;
  logic [XLEN-1:0]   dec_imm;
  logic              dec_illegal;

  modport master (
    output imem_req, imem_addr,
    input  imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_addr,
    output dec_valid, dec_pc, dec_ctrl, dec_imm, dec_illegal,
    input  dec_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rvalid, imem_rdata,
    output redirect_valid, redirect_addr,
    input  dec_valid, dec_pc, dec_ctrl, dec_imm, dec_illegal,
    output dec_ready
  );
endinterface

// File: rtl/rv_inst_decoder.sv
// rtl/rv_inst_decoder.sv - combinational RV instruction decoder
// Purpose: maps a 32-bit instruction word to the 12-bit control word, the
//          sign-extended immediate and an illegal flag.
// Ports:   instr (in 32), ctrl (out 12), imm (out XLEN), illegal (out 1).
module rv_inst_decoder
  import rv_dec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]       instr,
  output logic [CTRL_W-1:0] ctrl,
  output logic [XLEN-1:0]   imm,
  output logic              illegal
);
  localparam bit RV64 = (XLEN == 64);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       shamt_ok;
  fmt_e       fmt;
  logic [CTRL_W-1:0] c;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  // RV32 shift amounts are 5 bits, so instr[25] must be clear there.
  assign shamt_ok = RV64 || !instr[25];

  always_comb begin
    fmt = FMT_ILL;
    c   = '0;
    unique case (opc)
      OPC_OP: begin
        if ((f7 == F7_BASE && f3 != F3_SLTU) ||
            (f7 == F7_ALT && (f3 == F3_ADD_SUB || f3 == F3_SRL_SRA))) begin
          fmt              = FMT_R;
          c[CTRL_REGWRITE] = 1'b1;
          c[CTRL_ALT]      = instr[30];
          c[2:0]           = f3;
        end
      end
      OPC_OP_IMM: begin
        if ((f3 == F3_SLL && instr[31:26] == 6'b000000 && shamt_ok) ||
            (f3 == F3_SRL_SRA && shamt_ok &&
             (instr[31:26] == 6'b000000 || instr[31:26] == 6'b010000)) ||
            (f3 != F3_SLL && f3 != F3_SRL_SRA && f3 != F3_SLTU)) begin
          fmt              = FMT_I;
          c[CTRL_REGWRITE] = 1'b1;
          c[CTRL_ALUSRC]   = 1'b1;
          // Only srai carries the alternate bit; other immediates may have bit 30 set.
          c[CTRL_ALT]      = (f3 == F3_SRL_SRA) ? instr[30] : 1'b0;
          c[2:0]           = f3;
        end
      end
      OPC_LOAD: begin
        if (f3 == F3_DWORD) begin
          fmt              = FMT_I;
          c[CTRL_MEMREAD]  = 1'b1;
          c[CTRL_MEMTOREG] = 1'b1;
          c[CTRL_REGWRITE] = 1'b1;
          c[CTRL_ALUSRC]   = 1'b1;
        end
      end
      OPC_STORE: begin
        if (f3 == F3_DWORD) begin
          fmt              = FMT_S;
          c[CTRL_MEMWRITE] = 1'b1;
          c[CTRL_ALUSRC]   = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if (f3 == F3_BEQ || f3 == F3_BNE) begin
          fmt            = FMT_B;
          c[CTRL_BRANCH] = 1'b1;
          c[2:0]         = f3;
        end
      end
      OPC_JAL: begin
        fmt              = FMT_J;
        c[CTRL_JAL]      = 1'b1;
        c[CTRL_REGWRITE] = 1'b1;
      end
      OPC_JALR: begin
        if (f3 == F3_JALR) begin
          fmt              = FMT_I;
          c[CTRL_JALR]     = 1'b1;
          c[CTRL_REGWRITE] = 1'b1;
          c[CTRL_ALUSRC]   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    imm = '0;
    unique case (fmt)
      FMT_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      FMT_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
      FMT_J: imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  assign ctrl    = c;
  assign illegal = (fmt == FMT_ILL);

endmodule

// File: rtl/rv_fetch_decode.sv
// rtl/rv_fetch_decode.sv - fetch/decode front end with credit-limited decode queue
// Purpose: issues sequential word fetches, decodes returned words and buffers
//          them in a QDEPTH-entry circular queue for the execute stage.
// Ports:   clk, rst_n (async active-low), bus (rv_fetch_decode_if.master):
//          imem_req/imem_addr out, imem_rvalid/imem_rdata in,
//          redirect_valid/redirect_addr in, dec_valid/dec_pc/dec_ctrl/
//          dec_imm/dec_illegal out, dec_ready in.
module rv_fetch_decode
  import rv_dec_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              AW       = 30,
  parameter int              QDEPTH   = 2,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input logic                clk,
  input logic                rst_n,
  rv_fetch_decode_if.master  bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0]     pc;
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   imm;
    logic              illegal;
  } entry_t;

  fd_state_e     state_q, state_d;
  logic [AW-1:0] fpc_q, fpc_d;
  logic          inflight_q, inflight_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        mem_q [QDEPTH];
  entry_t        mem_d [QDEPTH];

  logic [CTRL_W-1:0] dcd_ctrl;
  logic [XLEN-1:0]   dcd_imm;
  logic              dcd_illegal;

  logic          run;
  logic          pop;
  logic          push;
  logic          redirect;
  logic          req;
  logic [CW:0]   occupancy;

  rv_inst_decoder #(.XLEN(XLEN)) u_decoder (
    .instr   (bus.imem_rdata),
    .ctrl    (dcd_ctrl),
    .imm     (dcd_imm),
    .illegal (dcd_illegal)
  );

  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    mem_d      = mem_q;
    inflight_d = 1'b0;

    unique case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase

    run      = (state_q == ST_RUN);
    pop      = (count_q != '0) && bus.dec_ready;
    redirect = run && bus.redirect_valid;
    push     = run && bus.imem_rvalid && !bus.redirect_valid;

    // Entries that will occupy the queue once everything already requested
    // has returned; a new request is only allowed if it still fits.
    occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    req       = run && !bus.redirect_valid && (occupancy < (CW+1)'(QDEPTH));

    if (pop) begin
      head_d = head_q + 1'b1;
    end
    if (push) begin
      mem_d[tail_q] = '{pc: fpc_q - 1'b1, ctrl: dcd_ctrl, imm: dcd_imm,
                        illegal: dcd_illegal};
      tail_d = tail_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);

    if (redirect) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      fpc_d   = bus.redirect_addr;
    end else if (req) begin
      fpc_d = fpc_q + 1'b1;
    end

    inflight_d = req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fpc_q      <= RESET_PC;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fpc_q      <= fpc_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fpc_q;
  assign bus.dec_valid   = (count_q != '0);
  assign bus.dec_pc      = mem_q[head_q].pc;
  assign bus.dec_ctrl    = mem_q[head_q].ctrl;
  assign bus.dec_imm     = mem_q[head_q].imm;
  assign bus.dec_illegal = mem_q[head_q].illegal;

endmodule

// File: tb/tb_rv_fetch_decode.sv
// tb/tb_rv_fetch_decode.sv - randomized self-checking bench for rv_fetch_decode
module tb_rv_fetch_decode;
  localparam int XLEN = 32;
  localparam int AW = 30;
  localparam int QDEPTH = 2;
  localparam logic [AW-1:0] RESET_PC = '0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rv_fetch_decode_if #(.XLEN(XLEN), .AW(AW)) bus ();

  rv_fetch_decode #(.XLEN(XLEN), .AW(AW), .QDEPTH(QDEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Legal instruction table: (mask, match) identifies the mnemonic.
  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [11:0] ctrl;
    int          fmt;   // 0 R, 1 I, 2 S, 3 B, 4 J
  } pat_t;
  pat_t pats[$];

  localparam logic [31:0] M_R = 32'hFE00707F;
  localparam logic [31:0] M_I = 32'h0000707F;
  localparam logic [31:0] M_J = 32'h0000007F;

  task automatic add_pat(input logic [31:0] m, input logic [31:0] v, input logic [11:0] c, input int f);
    pat_t p;
    p.mask = m; p.match = v; p.ctrl = c; p.fmt = f;
    pats.push_back(p);
  endtask

  function automatic void ref_dec(input logic [31:0] w, output logic [11:0] c,
                                  output logic [XLEN-1:0] imm, output logic ill);
    c = '0; imm = '0; ill = 1'b1;
    foreach (pats[i]) begin
      if ((w & pats[i].mask) == pats[i].match) begin
        ill = 1'b0;
        c = pats[i].ctrl;
        case (pats[i].fmt)
          1: imm = XLEN'($signed(w[31:20]));
          2: imm = XLEN'($signed({w[31:25], w[11:7]}));
          3: imm = XLEN'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
          4: imm = XLEN'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
          default: imm = '0;
        endcase
      end
    end
  endfunction

  logic [31:0] mem [64];
  logic [11:0] lit_ctrl [8];
  logic [31:0] lit_imm [8];
  logic        lit_ill [8];

  typedef struct {
    logic [AW-1:0] pc;
    logic [31:0]   w;
  } ent_t;
  ent_t q[$];

  logic [AW-1:0] exp_fpc, resp_addr;
  bit resp_pending, inflight, running;
  bit obs_req, obs_valid;
  logic [AW-1:0] obs_addr, obs_pc;
  int cyc, first_req_cyc, first_valid_cyc;
  logic [AW-1:0] first_req_addr;

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input bit rdy, input bit redir, input logic [AW-1:0] raddr);
    logic [11:0] rc;
    logic [XLEN-1:0] ri;
    logic rill;
    bit pop, exp_req;
    ent_t e;
    bus.imem_rvalid    = resp_pending;
    bus.imem_rdata     = resp_pending ? mem[resp_addr[5:0]] : $urandom;
    bus.redirect_valid = redir;
    bus.redirect_addr  = raddr;
    bus.dec_ready      = rdy;
    #1;
    obs_req = bus.imem_req; obs_addr = bus.imem_addr;
    obs_valid = bus.dec_valid; obs_pc = bus.dec_pc;
    if (obs_req && first_req_cyc < 0) begin first_req_cyc = cyc; first_req_addr = obs_addr; end
    if (obs_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

    chk("dec_valid", bus.dec_valid, q.size() != 0);
    if (q.size() != 0) begin
      ref_dec(q[0].w, rc, ri, rill);
      chk("dec_pc", bus.dec_pc, q[0].pc);
      chk("dec_ctrl", bus.dec_ctrl, rc);
      chk("dec_imm", bus.dec_imm, ri);
      chk("dec_illegal", bus.dec_illegal, rill);
      if (q[0].pc[5:0] < 6'd8) begin
        chk("lit_ctrl", bus.dec_ctrl, lit_ctrl[q[0].pc[2:0]]);
        chk("lit_imm", bus.dec_imm, lit_imm[q[0].pc[2:0]]);
        chk("lit_illegal", bus.dec_illegal, lit_ill[q[0].pc[2:0]]);
      end
    end
    pop = (q.size() != 0) && rdy;
    exp_req = running && !redir && (q.size() + int'(inflight) - int'(pop) < QDEPTH);
    chk("imem_req", obs_req, exp_req);
    chk("imem_addr", obs_addr, exp_fpc);

    if (pop) void'(q.pop_front());
    if (redir) q.delete();
    else if (resp_pending) begin
      e.pc = resp_addr; e.w = mem[resp_addr[5:0]];
      q.push_back(e);
    end
    resp_pending = exp_req;
    resp_addr = exp_fpc;
    if (running && redir) exp_fpc = raddr;
    else if (exp_req) exp_fpc = exp_fpc + 1'b1;
    inflight = exp_req;
    running = 1'b1;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int k;
    bit rdy, rd;
    logic [AW-1:0] ra;

    add_pat(M_R, 32'h00000033, 12'h020, 0); // add
    add_pat(M_R, 32'h40000033, 12'h028, 0); // sub
    add_pat(M_R, 32'h00001033, 12'h021, 0); // sll
    add_pat(M_R, 32'h00002033, 12'h022, 0); // slt
    add_pat(M_R, 32'h00004033, 12'h024, 0); // xor
    add_pat(M_R, 32'h00005033, 12'h025, 0); // srl
    add_pat(M_R, 32'h40005033, 12'h02D, 0); // sra
    add_pat(M_R, 32'h00006033, 12'h026, 0); // or
    add_pat(M_R, 32'h00007033, 12'h027, 0); // and
    add_pat(M_I, 32'h00000013, 12'h030, 1); // addi
    add_pat(M_R, 32'h00001013, 12'h031, 1); // slli
    add_pat(M_I, 32'h00002013, 12'h032, 1); // slti
    add_pat(M_I, 32'h00004013, 12'h034, 1); // xori
    add_pat(M_R, 32'h00005013, 12'h035, 1); // srli
    add_pat(M_R, 32'h40005013, 12'h03D, 1); // srai
    add_pat(M_I, 32'h00006013, 12'h036, 1); // ori
    add_pat(M_I, 32'h00007013, 12'h037, 1); // andi
    add_pat(M_I, 32'h00003003, 12'h170, 1); // ld
    add_pat(M_I, 32'h00000067, 12'h430, 1); // jalr
    add_pat(M_I, 32'h00003023, 12'h090, 2); // sd
    add_pat(M_I, 32'h00000063, 12'h200, 3); // beq
    add_pat(M_I, 32'h00001063, 12'h201, 3); // bne
    add_pat(M_J, 32'h0000006F, 12'h820, 4); // jal

    // addi x1,x0,-1 ; sub ; srai x4,x1,3 ; sd x2,8(x1) ; beq +16 ; bne +16 ; jal -8 ; illegal
    mem[0] = 32'hFFF00093; mem[1] = 32'h402081B3; mem[2] = 32'h4030D213; mem[3] = 32'h0020B423;
    mem[4] = 32'h00208863; mem[5] = 32'h00209863; mem[6] = 32'hFF9FF0EF; mem[7] = 32'hFFFFFFFF;
    lit_ctrl = '{12'h030, 12'h028, 12'h03D, 12'h090, 12'h200, 12'h201, 12'h820, 12'h000};
    lit_imm  = '{32'hFFFFFFFF, 32'h0, 32'h403, 32'h8, 32'h10, 32'h10, 32'hFFFFFFF8, 32'h0};
    lit_ill  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 8; i < 64; i++) begin
      if ($urandom_range(0, 4) == 0) mem[i] = $urandom;
      else begin
        k = $urandom_range(0, pats.size() - 1);
        mem[i] = pats[k].match | ($urandom & ~pats[k].mask);
      end
    end

    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.redirect_valid = 1'b0; bus.redirect_addr = '0; bus.dec_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_imem_addr", bus.imem_addr, RESET_PC);
    chk("rst_dec_valid", bus.dec_valid, 0);
    chk("rst_dec_pc", bus.dec_pc, 0);
    chk("rst_dec_ctrl", bus.dec_ctrl, 0);
    chk("rst_dec_imm", bus.dec_imm, 0);
    chk("rst_dec_illegal", bus.dec_illegal, 0);
    rst_n = 1'b1;
    exp_fpc = RESET_PC; resp_pending = 0; inflight = 0; running = 0;
    cyc = 0; first_req_cyc = -1; first_valid_cyc = -1;

    // Directed stream at address 0
    repeat (12) cycle(1'b1, 1'b0, '0);
    chk("first_req_cycle", first_req_cyc, 1);
    chk("first_req_addr", first_req_addr, 0);
    chk("req_to_valid", first_valid_cyc - first_req_cyc, 2);

    // Consumer stall: fetch must stop once the queue is committed
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, '0);
      if (i >= 1) chk("stall_req", obs_req, 0);
    end
    repeat (4) cycle(1'b1, 1'b0, '0);

    // Redirect while a response is arriving
    cycle(1'b1, 1'b1, AW'(32'h40));
    cycle(1'b1, 1'b0, '0);
    chk("redir_req", obs_req, 1);
    chk("redir_addr", obs_addr, 32'h40);
    for (int i = 0; i < 8 && !obs_valid; i++) cycle(1'b1, 1'b0, '0);
    chk("redir_valid", obs_valid, 1);
    chk("redir_pc", obs_pc, 32'h40);

    // Fetch pointer wrap
    cycle(1'b1, 1'b1, '1);
    cycle(1'b1, 1'b0, '0);
    chk("wrap_pre", obs_addr, {AW{1'b1}});
    cycle(1'b1, 1'b0, '0);
    chk("wrap_req", obs_req, 1);
    chk("wrap_addr", obs_addr, 0);

    // Random traffic
    repeat (600) begin
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 24) == 0);
      ra  = ($urandom_range(0, 3) == 0) ? AW'({AW{1'b1}} - AW'($urandom_range(0, 15)))
                                        : AW'($urandom_range(0, 63));
      cycle(rdy, rd, ra);
    end

    // Reset in the middle of traffic clears everything at once
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.dec_valid, 0);
    chk("mid_rst_req", bus.imem_req, 0);
    chk("mid_rst_addr", bus.imem_addr, RESET_PC);
    chk("mid_rst_pc", bus.dec_pc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
